button_reader: RTL and testbench

BUTTON_READER -- requirements
Module: button_reader

---
 rtl/button_reader.sv | 137 +++++++++++++
 tb/tb_button_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_reader.sv
// Push-button front end: synchronizer, debouncer, short/long press classifier
// and the LED colour/enable state that the button drives.
module button_reader #(
  parameter int DEB_CYCLES  = 480000,
  parameter int LONG_CYCLES = 24000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_short,
  output logic press_long,
  output logic led_r,
  output logic led_g,
  output logic led_b
);

  localparam int MAX_CYCLES = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LONG = 2'd2
  } state_t;

  logic          sync_a;
  logic          sync_b;
  logic          sample;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] hold_cnt;
  state_t        state;
  state_t        state_next;
  logic [2:0]    colour_idx;
  logic          enable;
  logic [2:0]    led;

  // Two-flop synchronizer; reset value 1 means "released" on the raw pin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
    end
  end

  assign sample = ~sync_b;

  // Debouncer: the level only moves after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pressed <= 1'b0;
      deb_cnt <= '0;
    end else if (sample == pressed) begin
      deb_cnt <= '0;
    end else if (deb_cnt >= DEB_LAST) begin
      pressed <= sample;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reaching the long boundary wins over a simultaneous release.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pressed) state_next = HOLD;
      HOLD: begin
        if (hold_cnt == LONG_LAST) begin
          state_next = LONG;
        end else if (!pressed) begin
          state_next = IDLE;
        end
      end
      LONG: if (!pressed) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: hold_cnt <= '0;
        HOLD: if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
        default: hold_cnt <= hold_cnt;
      endcase
    end
  end

  // Pulses are masked while reset is low so an aborted press never reports.
  always_comb begin
    press_long  = 1'b0;
    press_short = 1'b0;
    if (rst && state == HOLD) begin
      press_long  = (hold_cnt == LONG_LAST);
      press_short = (hold_cnt != LONG_LAST) && !pressed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      colour_idx <= 3'd0;
      enable     <= 1'b1;
    end else begin
      if (press_short) colour_idx <= colour_idx + 3'd1;
      if (press_long)  enable     <= ~enable;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led <= 3'b000;
    end else begin
      led <= enable ? colour_idx : 3'b000;
    end
  end

  assign {led_r, led_g, led_b} = led;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed press scenarios with literal expectations
// plus randomized button/reset activity compared every cycle to a reference model.
module tb_button_reader;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic btn_n = 1'b1;
  logic pressed, press_short, press_long, led_r, led_g, led_b;

  always #5 clk = ~clk;

  button_reader #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .pressed(pressed), .press_short(press_short), .press_long(press_long),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: values the outputs must show after each rising edge.
  int cyc = 0;
  bit started = 0;
  bit m_s1 = 1, m_s2 = 1;
  bit samp_q[$];
  bit m_pressed = 0, m_was, m_rose, m_fell, m_all_diff, m_samp;
  bit in_press = 0;
  int t_rise = 0;
  bit m_short = 0, m_long = 0;
  int m_idx = 0;
  bit m_en = 1;
  int m_led = 0;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (!rst) begin
      m_s1 = 1; m_s2 = 1;
      samp_q.delete();
      m_pressed = 0; in_press = 0;
      m_short = 0; m_long = 0;
      m_idx = 0; m_en = 1; m_led = 0;
    end else begin
      m_led = m_en ? m_idx : 0;
      if (m_short) m_idx = (m_idx + 1) % 8;
      if (m_long) m_en = !m_en;
      m_samp = !m_s2;
      m_s2 = m_s1;
      m_s1 = btn_n;
      samp_q.push_back(m_samp);
      if (samp_q.size() > DEB) void'(samp_q.pop_front());
      m_was = m_pressed;
      if (samp_q.size() == DEB) begin
        m_all_diff = 1;
        foreach (samp_q[i]) if (samp_q[i] == m_pressed) m_all_diff = 0;
        if (m_all_diff) m_pressed = !m_pressed;
      end
      m_rose = m_pressed && !m_was;
      m_fell = !m_pressed && m_was;
      m_long  = in_press && (cyc - t_rise == LONG);
      m_short = in_press && m_fell && (cyc - t_rise < LONG);
      if (m_fell) in_press = 0;
      if (m_rose) begin
        in_press = 1;
        t_rise = cyc;
      end
    end
  end

  // Compare and event monitor, away from the active edge.
  int short_cnt = 0, long_cnt = 0, rise_cnt = 0;
  int last_rise_cyc = 0, last_long_cyc = 0;
  logic prev_pressed = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      check("pressed", pressed, m_pressed);
      check("press_short", press_short, m_short && rst);
      check("press_long", press_long, m_long && rst);
      check("leds", {led_r, led_g, led_b}, m_led);
      if (press_short === 1'b1) short_cnt++;
      if (press_long === 1'b1) begin
        long_cnt++;
        last_long_cyc = cyc;
      end
      if (pressed === 1'b1 && prev_pressed !== 1'b1) begin
        rise_cnt++;
        last_rise_cyc = cyc;
      end
      prev_pressed = pressed;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int low, input int high);
    btn_n = 1'b0;
    step(low);
    btn_n = 1'b1;
    step(high);
  endtask

  int base_s, base_l, base_r, fall_cyc, w;

  initial begin
    rst = 1'b0;
    btn_n = 1'b1;
    step(3);
    rst = 1'b1;

    // Idle line
    step(50);
    check("idle_pressed", pressed, 0);
    check("idle_short_cnt", short_cnt, 0);
    check("idle_long_cnt", long_cnt, 0);
    check("idle_leds", {led_r, led_g, led_b}, 3'b000);

    // Glitch shorter than the debounce window
    base_r = rise_cnt; base_s = short_cnt;
    press(3, 15);
    check("glitch_rises", rise_cnt - base_r, 0);
    check("glitch_shorts", short_cnt - base_s, 0);

    // First short press: 2 sync + 4 debounce cycles to pressed
    base_s = short_cnt; base_l = long_cnt;
    fall_cyc = cyc;
    press(10, 25);
    check("short_rise_delay", last_rise_cyc - fall_cyc, 6);
    check("short1_shorts", short_cnt - base_s, 1);
    check("short1_longs", long_cnt - base_l, 0);
    check("short1_leds", {led_r, led_g, led_b}, 3'b001);

    // Seven more shorts step through the colours and wrap to 000
    for (int i = 0; i < 7; i++) begin
      press(10, 25);
      check("short_step_leds", {led_r, led_g, led_b}, (2 + i) % 8);
    end

    // Index 3, then a long press disables, a second long press restores
    for (int i = 0; i < 3; i++) press(8, 25);
    check("idx3_leds", {led_r, led_g, led_b}, 3'b011);
    base_s = short_cnt; base_l = long_cnt;
    press(40, 30);
    check("long1_longs", long_cnt - base_l, 1);
    check("long1_shorts", short_cnt - base_s, 0);
    check("long1_delay", last_long_cyc - last_rise_cyc, 20);
    check("long1_leds", {led_r, led_g, led_b}, 3'b000);
    press(40, 30);
    check("long2_longs", long_cnt - base_l, 2);
    check("long2_shorts", short_cnt - base_s, 0);
    check("long2_leds", {led_r, led_g, led_b}, 3'b011);

    // Reset in the middle of a hold, button still down
    base_s = short_cnt; base_l = long_cnt;
    btn_n = 1'b0;
    w = 0;
    while (pressed !== 1'b1 && w < 20) begin
      step(1);
      w++;
    end
    check("midreset_pressed_rise", pressed, 1);
    step(11);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check("midreset_pressed_cleared", pressed, 0);
    check("midreset_no_pulse", (short_cnt - base_s) + (long_cnt - base_l), 0);
    step(15);
    btn_n = 1'b1;
    step(25);
    check("midreset_shorts", short_cnt - base_s, 1);
    check("midreset_longs", long_cnt - base_l, 0);
    check("midreset_leds", {led_r, led_g, led_b}, 3'b001);

    // Random button activity with occasional resets
    repeat (150) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        step($urandom_range(1, 2));
        rst = 1'b1;
      end
      btn_n = 1'($urandom_range(0, 1));
      step($urandom_range(1, 30));
    end
    btn_n = 1'b1;
    step(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
